// File: rtl/fft_out_reorder_serializer.sv
// Captures one parallel FFT frame and streams it out one complex sample per beat,
// undoing the DIF bit-reversed slot order so samples leave in natural frequency order.
module fft_out_reorder_serializer #(
    parameter int N      = 8,
    parameter int LOG2N  = 3,
    parameter int DW     = 32,
    parameter bit BITREV = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [N-1:0][DW-1:0]   in_R,
    input  logic [N-1:0][DW-1:0]   in_I,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_R,
    output logic [DW-1:0]          out_I,
    output logic [LOG2N-1:0]       out_idx,
    output logic                   out_last,
    output logic                   busy
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    state_t                 state_q, state_d;
    logic [LOG2N-1:0]       cnt_q, cnt_d;
    logic [N-1:0][DW-1:0]   buf_r_q, buf_r_d;
    logic [N-1:0][DW-1:0]   buf_i_q, buf_i_d;
    logic                   capture;
    logic [LOG2N-1:0]       rd_idx;

    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
        return r;
    endfunction

    assign rd_idx = BITREV ? rev(cnt_q) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_r_d = buf_r_q;
        buf_i_d = buf_i_q;

        // A new frame may load on the final accepted beat, so streaming never bubbles.
        in_ready = (state_q == IDLE) ||
                   (state_q == STREAM && cnt_q == LAST && out_ready);
        capture  = in_valid && in_ready;

        if (state_q == STREAM && out_ready) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        if (capture) begin
            buf_r_d = in_R;
            buf_i_d = in_I;
            cnt_d   = '0;
            state_d = STREAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_r_q <= '0;
            buf_i_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_r_q <= buf_r_d;
            buf_i_q <= buf_i_d;
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;
    assign out_idx   = cnt_q;
    assign out_last  = out_valid && (cnt_q == LAST);
    assign out_R     = buf_r_q[rd_idx];
    assign out_I     = buf_i_q[rd_idx];
endmodule

// File: tb/tb_fft_out_reorder_serializer.sv
// Directed bench: reorder table, backpressure, back-to-back frames, mid-stream reset,
// and a pass-through instance with bit reversal disabled.
module tb_fft_out_reorder_serializer;
    localparam int N = 8, LOG2N = 3, DW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [N-1:0][DW-1:0] in_R, in_I;
    logic                 out_ready;
    logic                 in_ready, out_valid, out_last, busy;
    logic [DW-1:0]        out_R, out_I;
    logic [LOG2N-1:0]     out_idx;
    logic                 in_ready1, out_valid1, out_last1, busy1;
    logic [DW-1:0]        out_R1, out_I1;
    logic [LOG2N-1:0]     out_idx1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DW-1:0]    r;
        logic [DW-1:0]    i;
        logic [LOG2N-1:0] idx;
        logic             last;
    } vec_t;
    vec_t tv[N];

    always #5 clk = ~clk;

    fft_out_reorder_serializer #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_R(in_R), .in_I(in_I),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_I(out_I), .out_idx(out_idx), .out_last(out_last), .busy(busy));

    fft_out_reorder_serializer #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_R(in_R), .in_I(in_I),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_R(out_R1), .out_I(out_I1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    task automatic frame_a();
        for (int i = 0; i < N; i++) begin
            in_R[i] = DW'(100 * i);
            in_I[i] = DW'(-i);
        end
    endtask

    task automatic frame_b();
        for (int i = 0; i < N; i++) begin
            in_R[i] = DW'(1000 + i);
            in_I[i] = '0;
        end
    endtask

    // Waits (bounded) for the current frame to finish; a timeout counts as a failure.
    task automatic drain();
        int t = 0;
        while (out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        tv[0] = '{32'd0,   32'd0,      3'd0, 1'b0};
        tv[1] = '{32'd400, -32'sd4,    3'd1, 1'b0};
        tv[2] = '{32'd200, -32'sd2,    3'd2, 1'b0};
        tv[3] = '{32'd600, -32'sd6,    3'd3, 1'b0};
        tv[4] = '{32'd100, -32'sd1,    3'd4, 1'b0};
        tv[5] = '{32'd500, -32'sd5,    3'd5, 1'b0};
        tv[6] = '{32'd300, -32'sd3,    3'd6, 1'b0};
        tv[7] = '{32'd700, -32'sd7,    3'd7, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        frame_a();

        // Reset held while inputs toggle
        for (int c = 0; c < 3; c++) begin
            in_valid = c[0];
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_busy",      {31'd0, busy},      32'd0);
            chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
            chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
            chk("rst_out_R",     out_R,              32'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, table-driven, both instances
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t2_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t2_R[%0d]", k),     out_R,              tv[k].r);
            chk($sformatf("t2_I[%0d]", k),     out_I,              tv[k].i);
            chk($sformatf("t2_idx[%0d]", k),   {29'd0, out_idx},   {29'd0, tv[k].idx});
            chk($sformatf("t2_last[%0d]", k),  {31'd0, out_last},  {31'd0, tv[k].last});
            chk($sformatf("t2_in_ready[%0d]", k), {31'd0, in_ready}, (k == N-1) ? 32'd1 : 32'd0);
            chk($sformatf("t6_R[%0d]", k),     out_R1,             DW'(100 * k));
            chk($sformatf("t6_I[%0d]", k),     out_I1,             DW'(-k));
            @(negedge clk);
        end
        chk("t2_idle_after", {31'd0, out_valid}, 32'd0);

        // Backpressure at beat 2
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_beat2_R", out_R, 32'd200);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_R",     out_R,              32'd200);
            chk("t3_hold_I",     out_I,              -32'sd2);
            chk("t3_hold_idx",   {29'd0, out_idx},   32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_beat3_R",   out_R,            32'd600);
        chk("t3_beat3_idx", {29'd0, out_idx}, 32'd3);
        drain();

        // Back-to-back: B held on in_valid during A, captured on A's last beat
        frame_a();
        in_valid = 1'b1;
        @(negedge clk);
        frame_b();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t4_A_R[%0d]", k), out_R, tv[k].r);
            if (k < N-1) @(negedge clk);
        end
        chk("t4_A_last",     {31'd0, out_last}, 32'd1);
        chk("t4_A_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_B0_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_B0_idx",   {29'd0, out_idx},   32'd0);
        chk("t4_B0_R",     out_R,              32'd1000);
        @(negedge clk);
        chk("t4_B1_R",     out_R,              32'd1004);
        drain();

        // Reset pulse mid-stream at beat 4
        frame_a();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_beat4_R", out_R, 32'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_post_valid",    {31'd0, out_valid}, 32'd0);
            chk("t5_post_busy",     {31'd0, busy},      32'd0);
            chk("t5_post_in_ready", {31'd0, in_ready},  32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
